// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the EX-stage issue logic and the divider.
interface div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            div_start;
  logic [1:0]      div_op;
  logic [XLEN-1:0] div_in1;
  logic [XLEN-1:0] div_in2;
  logic            div_flush;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_start, div_op, div_in1, div_in2, div_flush,
    input  div_busy, div_done, div_result
  );

  modport slave (
    input  div_start, div_op, div_in1, div_in2, div_flush,
    output div_busy, div_done, div_result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: special cases and |dividend| < |divisor| skip CALC.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave div_if
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CntW-1:0] count_q;
  logic            rem_sel_q, neg_quo_q, neg_rem_q;
  logic            special_q;
  logic [XLEN-1:0] special_res_q;

  // Operand decode for the start cycle
  logic            signed_op, a_neg, b_neg, div_zero, ovf, special_hit;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    signed_op = ~div_if.div_op[0];
    a_neg     = signed_op & div_if.div_in1[XLEN-1];
    b_neg     = signed_op & div_if.div_in2[XLEN-1];
    a_mag     = a_neg ? -div_if.div_in1 : div_if.div_in1;
    b_mag     = b_neg ? -div_if.div_in2 : div_if.div_in2;
    div_zero  = (div_if.div_in2 == '0);
    ovf       = signed_op && (div_if.div_in1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                (div_if.div_in2 == '1);
    special_hit = div_zero | ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = div_if.div_op[1] ? div_if.div_in1 : '1;
    end else if (ovf) begin
      special_res = div_if.div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`ifdef DIV_EARLY_OUT_EN
    else if (a_mag < b_mag) begin
      // Quotient 0; remainder already carries the dividend's sign.
      special_hit = 1'b1;
      special_res = div_if.div_op[1] ? div_if.div_in1 : '0;
    end
`endif
  end

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic            borrow;
  logic [XLEN-1:0] rem_d, quo_d, quo_fix, rem_fix, final_res;

  always_comb begin
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    diff      = {1'b0, rem_sh} - {2'b00, dvs_q};
    borrow    = diff[XLEN+1];
    rem_d     = borrow ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], ~borrow};
    quo_fix   = neg_quo_q ? -quo_d : quo_d;
    rem_fix   = neg_rem_q ? -rem_d : rem_d;
    final_res = special_q ? special_res_q : (rem_sel_q ? rem_fix : quo_fix);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      count_q       <= '0;
      rem_sel_q     <= 1'b0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
    end else if (div_if.div_flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (div_if.div_start) begin
            rem_sel_q     <= div_if.div_op[1];
            neg_quo_q     <= a_neg ^ b_neg;
            neg_rem_q     <= a_neg;
            special_q     <= special_hit;
            special_res_q <= special_res;
            rem_q         <= '0;
            quo_q         <= a_mag;
            dvs_q         <= b_mag;
            count_q       <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (special_hit) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= StCalc;
              busy_q  <= 1'b1;
            end
`else
            state_q <= StCalc;
            busy_q  <= 1'b1;
`endif
          end
        end
        StCalc: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 1'b1;
          if (count_q == CntW'(XLEN - 1)) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_res;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.div_busy   = busy_q;
  assign div_if.div_done   = done_q;
  assign div_if.div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed fixup, special cases, flush, reset.
module tb_div_unit;

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;
`ifdef DIV_EARLY_OUT_EN
  localparam int SpecLat = 1;
  localparam int SpecBusy = 0;
`else
  localparam int SpecLat = 33;
  localparam int SpecBusy = 32;
`endif

  logic clk, rst;
  int   errors, checks;

  div_unit_if #(.XLEN(32)) dif ();

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op (start sampled at edge ending cycle T) and wait for done.
  // lat = cycle offset of done relative to T (0 on timeout); busy_n = busy cycles before done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output logic [31:0] res);
    @(posedge clk); #1;
    dif.div_start = 1'b1;
    dif.div_op    = op;
    dif.div_in1   = a;
    dif.div_in2   = b;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    lat = 0; busy_n = 0; res = '0;
    for (int i = 1; i <= 60; i++) begin
      if (dif.div_done) begin
        lat = i;
        res = dif.div_result;
        break;
      end
      if (dif.div_busy) busy_n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dif.div_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", dif.div_busy); end
    checks++; if (dif.div_done !== 1'b0) begin errors++;
      $display("FAIL reset_done: got %b want 0", dif.div_done); end
    checks++; if (dif.div_result !== 32'h0) begin errors++;
      $display("FAIL reset_result: got %h want 00000000", dif.div_result); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, bn; logic [31:0] res;
    run_op(OpDivu, 32'd100, 32'd7, lat, bn, res);
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL divu_latency: got %0d want 33", lat); end
    checks++; if (bn !== 32) begin errors++;
      $display("FAIL divu_busy_cycles: got %0d want 32", bn); end
    checks++; if (res !== 32'd14) begin errors++;
      $display("FAIL divu_100_7: got %h want 0000000e", res); end
    checks++; if (dif.div_busy !== 1'b0) begin errors++;
      $display("FAIL busy_in_done: got %b want 0", dif.div_busy); end
    @(posedge clk); #1;
    checks++; if (dif.div_done !== 1'b0) begin errors++;
      $display("FAIL done_one_cycle: got %b want 0", dif.div_done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dif.div_result !== 32'd14) begin errors++;
      $display("FAIL result_held: got %h want 0000000e", dif.div_result); end
    run_op(OpRemu, 32'd100, 32'd7, lat, bn, res);
    checks++; if (res !== 32'd2) begin errors++;
      $display("FAIL remu_100_7: got %h want 00000002", res); end
  endtask

  task automatic test_signed();
    int lat, bn; logic [31:0] res;
    run_op(OpDiv, 32'hFFFFFFF9, 32'd2, lat, bn, res);
    checks++; if (res !== 32'hFFFFFFFD) begin errors++;
      $display("FAIL div_m7_2: got %h want fffffffd", res); end
    run_op(OpRem, 32'hFFFFFFF9, 32'd2, lat, bn, res);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL rem_m7_2: got %h want ffffffff", res); end
    run_op(OpDiv, 32'd7, 32'hFFFFFFFE, lat, bn, res);
    checks++; if (res !== 32'hFFFFFFFD) begin errors++;
      $display("FAIL div_7_m2: got %h want fffffffd", res); end
    run_op(OpRem, 32'd7, 32'hFFFFFFFE, lat, bn, res);
    checks++; if (res !== 32'd1) begin errors++;
      $display("FAIL rem_7_m2: got %h want 00000001", res); end
    run_op(OpDiv, 32'h80000000, 32'd2, lat, bn, res);
    checks++; if (res !== 32'hC0000000) begin errors++;
      $display("FAIL div_min_2: got %h want c0000000", res); end
  endtask

  task automatic test_overflow();
    int lat, bn; logic [31:0] res;
    run_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, lat, bn, res);
    checks++; if (res !== 32'h80000000) begin errors++;
      $display("FAIL div_ovf: got %h want 80000000", res); end
    checks++; if (lat !== SpecLat) begin errors++;
      $display("FAIL div_ovf_latency: got %0d want %0d", lat, SpecLat); end
    run_op(OpRem, 32'h80000000, 32'hFFFFFFFF, lat, bn, res);
    checks++; if (res !== 32'h0) begin errors++;
      $display("FAIL rem_ovf: got %h want 00000000", res); end
  endtask

  task automatic test_div_zero();
    int lat, bn; logic [31:0] res;
    run_op(OpDivu, 32'd5, 32'd0, lat, bn, res);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL divu_5_0: got %h want ffffffff", res); end
    checks++; if (lat !== SpecLat) begin errors++;
      $display("FAIL div0_latency: got %0d want %0d", lat, SpecLat); end
    checks++; if (bn !== SpecBusy) begin errors++;
      $display("FAIL div0_busy_cycles: got %0d want %0d", bn, SpecBusy); end
    run_op(OpRem, 32'hFFFFFFFB, 32'd0, lat, bn, res);
    checks++; if (res !== 32'hFFFFFFFB) begin errors++;
      $display("FAIL rem_m5_0: got %h want fffffffb", res); end
    run_op(OpDiv, 32'hFFFFFFFB, 32'd0, lat, bn, res);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL div_m5_0: got %h want ffffffff", res); end
  endtask

  task automatic test_small();
    int lat, bn; logic [31:0] res;
    run_op(OpDivu, 32'd3, 32'd10, lat, bn, res);
    checks++; if (res !== 32'h0) begin errors++;
      $display("FAIL divu_3_10: got %h want 00000000", res); end
    checks++; if (lat !== SpecLat) begin errors++;
      $display("FAIL small_latency: got %0d want %0d", lat, SpecLat); end
    run_op(OpRem, 32'hFFFFFFFD, 32'd10, lat, bn, res);
    checks++; if (res !== 32'hFFFFFFFD) begin errors++;
      $display("FAIL rem_m3_10: got %h want fffffffd", res); end
  endtask

  task automatic test_flush();
    int lat, bn; logic [31:0] res, prev;
    logic saw_done;
    prev = dif.div_result;
    saw_done = 1'b0;
    @(posedge clk); #1;
    dif.div_start = 1'b1; dif.div_op = OpDivu; dif.div_in1 = 32'd1000; dif.div_in2 = 32'd3;
    @(posedge clk); #1;                // cycle T+1
    dif.div_start = 1'b0;
    for (int i = 0; i < 9; i++) begin  // advance to cycle T+10
      if (dif.div_done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    dif.div_flush = 1'b1;
    @(posedge clk); #1;                // cycle T+11
    dif.div_flush = 1'b0;
    checks++; if (dif.div_busy !== 1'b0) begin errors++;
      $display("FAIL flush_busy: got %b want 0", dif.div_busy); end
    for (int i = 0; i < 40; i++) begin
      if (dif.div_done) saw_done = 1'b1;
      if (i == 0) break;               // next start must go in at T+12
    end
    checks++; if (dif.div_result !== prev) begin errors++;
      $display("FAIL flush_result: got %h want %h", dif.div_result, prev); end
    run_op(OpDivu, 32'd9, 32'd3, lat, bn, res);
    checks++; if (res !== 32'd3) begin errors++;
      $display("FAIL after_flush_result: got %h want 00000003", res); end
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL after_flush_latency: got %0d want 33", lat); end
    // Watch a flushed op to its would-be completion: no done pulse allowed.
    @(posedge clk); #1;
    dif.div_start = 1'b1; dif.div_op = OpDivu; dif.div_in1 = 32'd77; dif.div_in2 = 32'd7;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    dif.div_flush = 1'b1;
    @(posedge clk); #1;
    dif.div_flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dif.div_done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++;
      $display("FAIL flush_no_done: got %b want 0", saw_done); end
    checks++; if (dif.div_result !== 32'd3) begin errors++;
      $display("FAIL flush_result_kept: got %h want 00000003", dif.div_result); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic [31:0] res;
    lat = 0;
    @(posedge clk); #1;
    dif.div_start = 1'b1; dif.div_op = OpDivu; dif.div_in1 = 32'd50; dif.div_in2 = 32'd5;
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin                // stray start mid-CALC must be ignored
        dif.div_start = 1'b1; dif.div_in1 = 32'd99; dif.div_in2 = 32'd1;
      end else begin
        dif.div_start = 1'b0;
      end
      if (dif.div_done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    dif.div_start = 1'b0;
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL ignore_start_latency: got %0d want 33", lat); end
    checks++; if (dif.div_result !== 32'd10) begin errors++;
      $display("FAIL ignore_start_result: got %h want 0000000a", dif.div_result); end
    run_op(OpDivu, 32'd81, 32'd9, lat, bn, res);
    checks++; if (res !== 32'd9) begin errors++;
      $display("FAIL b2b_result: got %h want 00000009", res); end
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL b2b_latency: got %0d want 33", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, bn; logic [31:0] res;
    @(posedge clk); #1;
    dif.div_start = 1'b1; dif.div_op = OpDivu; dif.div_in1 = 32'd100; dif.div_in2 = 32'd7;
    @(posedge clk); #1;                // cycle T+1
    dif.div_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;                                // cycle T+5
    rst = 1'b1;
    #1;
    checks++; if (dif.div_busy !== 1'b0) begin errors++;
      $display("FAIL midrst_busy: got %b want 0", dif.div_busy); end
    checks++; if (dif.div_result !== 32'h0) begin errors++;
      $display("FAIL midrst_result: got %h want 00000000", dif.div_result); end
    checks++; if (dif.div_done !== 1'b0) begin errors++;
      $display("FAIL midrst_done: got %b want 0", dif.div_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(OpDivu, 32'd100, 32'd7, lat, bn, res);
    checks++; if (res !== 32'd14) begin errors++;
      $display("FAIL after_rst_result: got %h want 0000000e", res); end
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL after_rst_latency: got %0d want 33", lat); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    dif.div_start = 1'b0; dif.div_op = 2'b00; dif.div_in1 = '0; dif.div_in2 = '0;
    dif.div_flush = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_small();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
